chan_pkt_reader: RTL



---
 rtl/chan_pkt_reader_pkg.sv | 11 +
 rtl/chan_pkt_ts_cmp.sv | 20 ++
 rtl/chan_pkt_reader.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/chan_pkt_reader_pkg.sv
// chan_pkt_reader_pkg: shared state encodings, header layout and format codes for the TX channel packet reader.
package chan_pkt_reader_pkg;
    typedef enum logic [2:0] {IDLE, HEADER, TIMESTAMP, WAIT, WAITSTROBE, SEND, SEND_HI} state_t;
    localparam int HDR_SOB = 28;
    localparam int HDR_EOB = 27;
    localparam int HDR_RSSI = 26;
    localparam int HDR_LEN_LSB = 2;
    localparam logic [3:0] FMT_QI16 = 4'd0;
    localparam logic [3:0] FMT_QI8 = 4'd1;
    localparam logic [31:0] TS_NOW = 32'hFFFF_FFFF;
endpackage

// File: rtl/chan_pkt_ts_cmp.sv
// chan_pkt_ts_cmp: wrap-safe compare of a packet timestamp against adc_time and the send window.
module chan_pkt_ts_cmp
    import chan_pkt_reader_pkg::*;
#(
    parameter int JITTER = 5
) (
    input  logic [31:0] timestamp,
    input  logic [31:0] adc_time,
    output logic        late,
    output logic        in_window
);
    logic signed [31:0] d;
    logic now;
    always_comb begin
        d = $signed(timestamp - adc_time);
        now = timestamp == TS_NOW;
        late = !now && d <= 0;
        in_window = now || (d > 0 && d <= JITTER);
    end
endmodule

// File: rtl/chan_pkt_reader.sv
// chan_pkt_reader: parses header/timestamp from a show-ahead packet FIFO and feeds timed I/Q samples to tx_chain.
// Optional RSSI gating of SOB packets is built when RSSI_GATE_EN is defined.
module chan_pkt_reader
    import chan_pkt_reader_pkg::*;
#(
    parameter int LEN_W = 7,
    parameter int OUT_W = 16,
    parameter int JITTER = 5,
    parameter int DROP_W = 16
) (
    input  logic              tx_clock,
    input  logic              reset,
    input  logic              tx_strobe,
    input  logic [31:0]       adc_time,
    input  logic [3:0]        samples_format,
    input  logic [31:0]       fifodata,
    input  logic              pkt_waiting,
`ifdef RSSI_GATE_EN
    input  logic [31:0]       rssi,
    input  logic [31:0]       threshhold,
    input  logic [31:0]       rssi_wait,
`endif
    output logic              rdreq,
    output logic              skip,
    output logic [OUT_W-1:0]  tx_i,
    output logic [OUT_W-1:0]  tx_q,
    output logic              tx_empty,
    output logic              underrun,
    output logic [DROP_W-1:0] drop_count
);
    state_t state;
    logic trash, burst, late, in_window, drop, go, sob, eob;
    logic [LEN_W-1:0] len, read_len;
    logic [31:0] timestamp;
    logic [15:0] hi;

    // MSB-align a 16-bit field into OUT_W: truncates LSBs or zero-pads them
    function automatic logic [OUT_W-1:0] align(input logic [15:0] v);
        return OUT_W'({v, {OUT_W{1'b0}}} >> 16);
    endfunction

    chan_pkt_ts_cmp #(.JITTER(JITTER)) u_cmp (
        .timestamp(timestamp),
        .adc_time(adc_time),
        .late(late),
        .in_window(in_window)
    );

    assign sob = fifodata[HDR_SOB];
    assign eob = fifodata[HDR_EOB];

`ifdef RSSI_GATE_EN
    logic rssi_flag;
    logic [31:0] time_wait;
    assign drop = late || (rssi_flag && rssi_wait != 32'd0 && time_wait >= rssi_wait);
    assign go = in_window && (!rssi_flag || rssi <= threshhold);
`else
    assign drop = late;
    assign go = in_window;
`endif

    always_ff @(posedge tx_clock) begin
        if (reset) begin
            state <= IDLE;
            rdreq <= 1'b0;
            skip <= 1'b0;
            underrun <= 1'b0;
            tx_empty <= 1'b1;
            tx_i <= '0;
            tx_q <= '0;
            drop_count <= '0;
            trash <= 1'b0;
            burst <= 1'b0;
            len <= '0;
            read_len <= '0;
            timestamp <= '0;
            hi <= '0;
`ifdef RSSI_GATE_EN
            rssi_flag <= 1'b0;
            time_wait <= '0;
`endif
        end else begin
            if (tx_strobe && state != SEND && state != SEND_HI)
                tx_empty <= 1'b1;
            case (state)
                IDLE: begin
                    skip <= 1'b0;
                    underrun <= burst && !pkt_waiting;
`ifdef RSSI_GATE_EN
                    time_wait <= '0;
`endif
                    // the FIFO still shows the discarded packet while skip is high
                    if (pkt_waiting && !skip) begin
                        rdreq <= 1'b1;
                        state <= HEADER;
                    end
                end
                HEADER: begin
                    if (trash && !sob) begin
                        rdreq <= 1'b0;
                        skip <= 1'b1;
                        state <= IDLE;
                    end else begin
                        len <= fifodata[LEN_W+1:HDR_LEN_LSB];
                        read_len <= '0;
                        burst <= (sob || eob) ? sob && !eob : burst;
`ifdef RSSI_GATE_EN
                        rssi_flag <= fifodata[HDR_RSSI] && sob;
`endif
                        state <= TIMESTAMP;
                    end
                end
                TIMESTAMP: begin
                    timestamp <= fifodata;
                    rdreq <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
`ifdef RSSI_GATE_EN
                    time_wait <= time_wait + 32'd1;
`endif
                    if (drop) begin
                        trash <= 1'b1;
                        skip <= 1'b1;
                        drop_count <= drop_count + {{(DROP_W-1){1'b0}}, ~&drop_count};
                        state <= IDLE;
                    end else if (go) begin
                        trash <= 1'b0;
                        state <= WAITSTROBE;
                    end
                end
                WAITSTROBE: begin
                    if (read_len == len) begin
                        skip <= 1'b1;
                        state <= IDLE;
                    end else if (tx_strobe) begin
                        rdreq <= 1'b1;
                        state <= SEND;
                    end
                end
                SEND: begin
                    rdreq <= 1'b0;
                    read_len <= read_len + 1'b1;
                    tx_empty <= 1'b0;
                    if (samples_format == FMT_QI8) begin
                        tx_i <= align({fifodata[7:0], 8'h00});
                        tx_q <= align({fifodata[15:8], 8'h00});
                        hi <= fifodata[31:16];
                        state <= SEND_HI;
                    end else begin
                        tx_i <= align(fifodata[15:0]);
                        tx_q <= align(fifodata[31:16]);
                        state <= WAITSTROBE;
                    end
                end
                SEND_HI: begin
                    if (tx_strobe) begin
                        tx_i <= align({hi[7:0], 8'h00});
                        tx_q <= align({hi[15:8], 8'h00});
                        tx_empty <= 1'b0;
                        state <= WAITSTROBE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
